// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers BCD frames from a multiplexed active-low 7-segment scan
module seg_scan_decoder #(
  parameter logic [7:0]  STABLE_CYCLES  = 8'd64,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_n,
  input  logic [7:0]  dig_n,
  output logic [31:0] bcd_value,
  output logic [7:0]  blank_mask,
  output logic        frame_valid,
  output logic        frame_changed,
  output logic        seg_err,
  output logic        seq_err,
  output logic        stale
);
  typedef enum logic {HUNT, COLLECT} state_t;
  state_t      state;
  logic [7:0]  seg_m, seg_s, seg_p, dig_m, dig_s, dig_p, stab_cnt, zeros, blank_next;
  logic [23:0] to_cnt;
  logic [31:0] shadow;
  logic [2:0]  exp_d, k;
  logic [3:0]  nib;
  logic        same, sample, one_hot, legal, done, first_frame;
  // two-flop synchronizers plus a one-cycle history for change detection
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_m <= 8'hFF;
      seg_s <= 8'hFF;
      seg_p <= 8'hFF;
      dig_m <= 8'hFF;
      dig_s <= 8'hFF;
      dig_p <= 8'hFF;
    end else begin
      seg_m <= seg_n;
      seg_s <= seg_m;
      seg_p <= seg_s;
      dig_m <= dig_n;
      dig_s <= dig_m;
      dig_p <= dig_s;
    end
  end
  assign same   = {dig_s, seg_s} == {dig_p, seg_p};
  assign sample = same && stab_cnt == STABLE_CYCLES - 8'd1;
  // saturating stability counter; sample fires only on the step into saturation
  always_ff @(posedge clk) begin
    if (rst) stab_cnt <= 8'd0;
    else if (!same) stab_cnt <= 8'd0;
    else if (stab_cnt != STABLE_CYCLES) stab_cnt <= stab_cnt + 8'd1;
  end
  // digit index, one-hot check and segment-code decode of the sampled value
  always_comb begin
    zeros   = ~dig_s;
    one_hot = zeros != 8'h00 && (zeros & (zeros - 8'd1)) == 8'h00;
    k       = 3'd0;
    for (int i = 0; i < 8; i++) if (zeros[i]) k = 3'(i);
    legal = 1'b1;
    nib   = 4'hF;
    case (seg_s)
      8'hC0: nib = 4'd0;
      8'hF9: nib = 4'd1;
      8'hA4: nib = 4'd2;
      8'hB0: nib = 4'd3;
      8'h99: nib = 4'd4;
      8'h92: nib = 4'd5;
      8'h82: nib = 4'd6;
      8'hF8: nib = 4'd7;
      8'h80: nib = 4'd8;
      8'h90: nib = 4'd9;
      8'hFF: nib = 4'hF;
      default: legal = 1'b0;
    endcase
  end
  // frame assembly FSM: collects digits 0..7 in order into the shadow register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= HUNT;
      exp_d   <= 3'd0;
      shadow  <= 32'hFFFF_FFFF;
      done    <= 1'b0;
      seg_err <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      done    <= 1'b0;
      seg_err <= 1'b0;
      seq_err <= 1'b0;
      if (sample && dig_s != 8'hFF) begin
        if (!one_hot) begin
          seq_err <= 1'b1;
          state   <= HUNT;
        end else if (!legal) begin
          seg_err <= 1'b1;
          state   <= HUNT;
        end else if (state == HUNT) begin
          if (k == 3'd0) begin
            shadow[3:0] <= nib;
            exp_d       <= 3'd1;
            state       <= COLLECT;
          end
        end else if (k == exp_d) begin
          shadow[{k, 2'b00} +: 4] <= nib;
          exp_d <= exp_d + 3'd1;
          if (k == 3'd7) begin
            done  <= 1'b1;
            state <= HUNT;
          end
        end else if (k == exp_d - 3'd1) begin
          shadow[{k, 2'b00} +: 4] <= nib;
        end else if (k == 3'd0) begin
          seq_err     <= 1'b1;
          shadow[3:0] <= nib;
          exp_d       <= 3'd1;
        end else begin
          seq_err <= 1'b1;
          state   <= HUNT;
        end
      end
    end
  end
  // per-digit blank flags of the assembled frame
  always_comb begin
    blank_next = 8'h00;
    for (int i = 0; i < 8; i++) blank_next[i] = shadow[4*i +: 4] == 4'hF;
  end
  // publish the completed frame and run the staleness timer
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_value     <= 32'hFFFF_FFFF;
      blank_mask    <= 8'hFF;
      frame_valid   <= 1'b0;
      frame_changed <= 1'b0;
      first_frame   <= 1'b1;
      to_cnt        <= 24'd0;
    end else begin
      frame_valid   <= done;
      frame_changed <= done && (first_frame || shadow != bcd_value);
      if (done) begin
        bcd_value   <= shadow;
        blank_mask  <= blank_next;
        first_frame <= 1'b0;
      end
      to_cnt <= done ? 24'd0 : to_cnt != TIMEOUT_CYCLES ? to_cnt + 24'd1 : to_cnt;
    end
  end
  assign stale = to_cnt == TIMEOUT_CYCLES;
endmodule
